// File: rtl/plot_stream_sink.sv
// Pixel-plot sink: buffers drawer pixels in a small FIFO, drains them into a 160x120
// framebuffer write port, sweeps full-frame clears. Optional macro: PLOT_TRANSPARENT_EN.
module plot_stream_sink #(
    parameter int         DEPTH         = 4,
    parameter int         SYMBOL_PIXELS = 51,
    parameter logic [2:0] BG_COLOUR     = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    output logic        ready,
    input  logic        fb_busy,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_data,
    input  logic        frame_clear,
    output logic        clearing,
    output logic        sym_done,
    output logic [7:0]  drop_count,
    output logic [1:0]  state_dbg
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          PW        = AW + 1;
    localparam logic [14:0] LAST_ADDR = 15'd19199;
    localparam logic [5:0]  SYM_LAST  = 6'(SYMBOL_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [17:0]   mem [DEPTH];
    logic [PW-1:0] wptr, rptr, wptr_nx, rptr_nx;
    logic          clear_pending;
    logic [14:0]   clr_addr;
    logic [5:0]    sym_cnt;

    logic          accept, in_range, transparent, push, pop, bypass;
    logic          fifo_empty, fifo_full;
    logic [14:0]   in_addr;
    logic [17:0]   head;

    // Handshake: a pixel transfers in any cycle where plot and ready are both high;
    // ready never looks at a same-cycle pop, and a drawer seeing ready low holds its pixel.
    assign ready    = !reset && !fifo_full && (state != CLEAR) && !clear_pending;
    assign accept   = plot && ready;
    assign in_range = (x <= 8'd159) && (y <= 7'd119);

`ifdef PLOT_TRANSPARENT_EN
    assign transparent = (colour == 3'b000);
`else
    assign transparent = 1'b0;
`endif

    assign push       = accept && in_range && !transparent;
    assign in_addr    = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // An empty FIFO lets the incoming pixel fall straight through to the write register.
    assign head    = fifo_empty ? {in_addr, colour} : mem[rptr[AW-1:0]];
    assign pop     = !fb_busy && (state != CLEAR) && (!fifo_empty || push);
    assign bypass  = pop && fifo_empty;
    assign wptr_nx = wptr + PW'(push && !bypass);
    assign rptr_nx = rptr + PW'(pop && !bypass);

    assign clearing  = (state == CLEAR);
    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (clear_pending)
                    state_nx = CLEAR;
                else if (wptr_nx != rptr_nx)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (wptr_nx == rptr_nx)
                    state_nx = clear_pending ? CLEAR : IDLE;
            end
            CLEAR: begin
                if (!fb_busy && (clr_addr == LAST_ADDR))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wptr          <= '0;
            rptr          <= '0;
            clear_pending <= 1'b0;
            clr_addr      <= '0;
        end else begin
            state <= state_nx;
            wptr  <= wptr_nx;
            rptr  <= rptr_nx;
            if (state == CLEAR)
                clear_pending <= 1'b0;
            else if (frame_clear)
                clear_pending <= 1'b1;
            if (state != CLEAR)
                clr_addr <= '0;
            else if (!fb_busy)
                clr_addr <= (clr_addr == LAST_ADDR) ? 15'd0 : clr_addr + 15'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !bypass)
            mem[wptr[AW-1:0]] <= {in_addr, colour};
    end

    // Address/data only move when a write issues, so a stall leaves them stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else if (state == CLEAR) begin
            fb_we <= !fb_busy;
            if (!fb_busy) begin
                fb_addr <= clr_addr;
                fb_data <= BG_COLOUR;
            end
        end else begin
            fb_we <= pop;
            if (pop) begin
                fb_addr <= head[17:3];
                fb_data <= head[2:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_cnt    <= '0;
            sym_done   <= 1'b0;
            drop_count <= '0;
        end else begin
            sym_done <= accept && in_range && (sym_cnt == SYM_LAST) && !frame_clear;
            if (frame_clear)
                sym_cnt <= '0;
            else if (accept && in_range)
                sym_cnt <= (sym_cnt == SYM_LAST) ? 6'd0 : sym_cnt + 6'd1;
            if (accept && !in_range && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_plot_stream_sink.sv
// Self-checking bench for plot_stream_sink: scoreboard of expected framebuffer
// writes, symbol-pulse and drop-count model, clear sweep and reset-mid-clear.
module tb_plot_stream_sink;

`ifdef PLOT_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        ready;
    logic        fb_busy;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        frame_clear;
    logic        clearing;
    logic        sym_done;
    logic [7:0]  drop_count;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [17:0] exp_q[$];
    logic [17:0] exp_w;
    int          sym_m  = 0;
    int          drop_m = 0;

    plot_stream_sink dut (
        .clk         (clk),
        .reset       (reset),
        .plot        (plot),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .ready       (ready),
        .fb_busy     (fb_busy),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .frame_clear (frame_clear),
        .clearing    (clearing),
        .sym_done    (sym_done),
        .drop_count  (drop_count),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every framebuffer write must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && fb_we) begin
            if (exp_q.size() == 0) begin
                check("unexp_we", {31'b0, fb_we}, 32'd0);
            end else begin
                exp_w = exp_q.pop_front();
                check("fb_write", {14'b0, fb_addr, fb_data}, {14'b0, exp_w});
            end
        end
    end

    task automatic send(input int px, input int py, input int pc);
        int          waited = 0;
        bit          pulse  = 1'b0;
        logic [14:0] a;
        plot   = 1'b1;
        x      = px[7:0];
        y      = py[6:0];
        colour = pc[2:0];
        while (!ready && waited < 200) begin
            tick();
            fb_busy = 1'b0;
            waited++;
        end
        if (!ready) begin
            check("ready_timeout", {31'b0, ready}, 32'd1);
            plot = 1'b0;
            return;
        end
        if (px <= 159 && py <= 119) begin
            a = 15'(py * 160 + px);
            if (!(TRANSP && pc == 0))
                exp_q.push_back({a, pc[2:0]});
            sym_m++;
            if (sym_m == 51) begin
                sym_m = 0;
                pulse = 1'b1;
            end
        end else if (drop_m < 255) begin
            drop_m++;
        end
        tick();
        plot = 1'b0;
        check("sym_done", {31'b0, sym_done}, {31'b0, pulse});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        tick();
        check(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        int n_clr;
        reset       = 1'b1;
        plot        = 1'b0;
        x           = '0;
        y           = '0;
        colour      = '0;
        fb_busy     = 1'b0;
        frame_clear = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_fb_we", {31'b0, fb_we}, 32'd0);
        check("rst_fb_addr", {17'b0, fb_addr}, 32'd0);
        check("rst_fb_data", {29'b0, fb_data}, 32'd0);
        check("rst_clearing", {31'b0, clearing}, 32'd0);
        check("rst_sym_done", {31'b0, sym_done}, 32'd0);
        check("rst_drop", {24'b0, drop_count}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, ready}, 32'd1);

        // Single pixel: written in the very next cycle.
        send(10, 2, 6);
        check("t1_we", {31'b0, fb_we}, 32'd1);
        check("t1_addr", {17'b0, fb_addr}, 32'd330);
        check("t1_data", {29'b0, fb_data}, 32'd6);
        drain("t1_drain");

        // Stall: fill the FIFO, then release and expect back-to-back writes.
        fb_busy = 1'b1;
        send(0, 0, 1);
        send(159, 0, 2);
        send(0, 119, 3);
        send(159, 119, 4);
        check("t2_full_ready", {31'b0, ready}, 32'd0);
        check("t2_no_we", {31'b0, fb_we}, 32'd0);
        fb_busy = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t2_drain", exp_q.size(), 32'd0);

        // Out-of-range pixels are dropped and counted.
        send(160, 0, 5);
        send(0, 120, 5);
        tick();
        check("t3_drop", {24'b0, drop_count}, 32'd2);
        drain("t3_none");

        // Symbol pulses over a long random stream with random stalls.
        for (int i = 0; i < 110; i++) begin
            fb_busy = ($urandom_range(0, 3) == 0);
            send($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(1, 7));
        end
        fb_busy = 1'b0;
        drain("t4_drain");

        // Drop counter saturation.
        for (int i = 0; i < 260; i++)
            send($urandom_range(160, 255), $urandom_range(0, 127), $urandom_range(0, 7));
        tick();
        check("t3_drop_sat", {24'b0, drop_count}, 32'd255);

        // Frame clear with two queued pixels: pixels first, then the sweep.
        fb_busy = 1'b1;
        send(5, 5, 3);
        send(159, 119, 7);
        frame_clear = 1'b1;
        fb_busy     = 1'b0;
        for (int a = 0; a < 19200; a++) exp_q.push_back({15'(a), 3'b000});
        sym_m = 0;
        tick();
        frame_clear = 1'b0;
        check("t5_blocked", {31'b0, ready}, 32'd0);
        n_clr = 0;
        for (int i = 0; i < 20000 && (exp_q.size() != 0 || clearing); i++) begin
            if (clearing) n_clr++;
            tick();
        end
        check("t5_clear_cycles", n_clr, 32'd19200);
        check("t5_all_written", exp_q.size(), 32'd0);
        check("t5_ready", {31'b0, ready}, 32'd1);

        // Reset in the middle of a sweep.
        frame_clear = 1'b1;
        for (int a = 0; a < 19200; a++) exp_q.push_back({15'(a), 3'b000});
        tick();
        frame_clear = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        check("t6_clearing_before", {31'b0, clearing}, 32'd1);
        reset = 1'b1;
        tick();
        check("t6_clearing", {31'b0, clearing}, 32'd0);
        check("t6_fb_we", {31'b0, fb_we}, 32'd0);
        check("t6_ready", {31'b0, ready}, 32'd0);
        exp_q.delete();
        sym_m  = 0;
        drop_m = 0;
        reset  = 1'b0;
        #1;
        check("t6_ready_after", {31'b0, ready}, 32'd1);
        check("t6_drop", {24'b0, drop_count}, 32'd0);
        for (int i = 0; i < 5; i++) tick();

        // Colour 0 at (1,1) still counts toward the symbol.
        send(1, 1, 0);
        for (int i = 0; i < 50; i++)
            send($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(1, 7));
        drain("t7_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
